// File: rtl/rs_issue_scheduler.sv
// Reservation stations for one shared ALU: CDB wake-up, round-robin issue, one op in flight.
// Issue one cycle after a slot is seen ready; the result is held on out_* until out_grant frees the slot.
module rs_issue_scheduler #(
   parameter int ENTRIES  = 4,
   parameter int TAG_W    = 8,
   parameter int TAG_BASE = 1
) (
   input  logic             clk,
   input  logic             RST,
   input  logic             flush,
   input  logic             alloc_valid,
   output logic             alloc_ready,
   input  logic [TAG_W-1:0] alloc_q1,
   input  logic [TAG_W-1:0] alloc_q2,
   input  logic [31:0]      alloc_v1,
   input  logic [31:0]      alloc_v2,
   output logic [TAG_W-1:0] alloc_tag,
   input  logic             cdb_valid,
   input  logic [TAG_W-1:0] cdb_tag,
   input  logic [31:0]      cdb_value,
   output logic             alu_valid,
   output logic [31:0]      alu_a,
   output logic [31:0]      alu_b,
   input  logic             alu_done,
   input  logic [31:0]      alu_result,
   output logic             out_valid,
   output logic [TAG_W-1:0] out_tag,
   output logic [31:0]      out_value,
   input  logic             out_grant
);
   localparam int IW = $clog2(ENTRIES);
   typedef logic [IW-1:0] idx_t;
   typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_BCAST, S_DRAIN} state_t;

   state_t             r_state;
   logic [ENTRIES-1:0] r_busy;
   logic [TAG_W-1:0]   r_q1 [ENTRIES];
   logic [TAG_W-1:0]   r_q2 [ENTRIES];
   logic [31:0]        r_v1 [ENTRIES];
   logic [31:0]        r_v2 [ENTRIES];
   idx_t               r_idx;
   idx_t               r_rr_ptr;
   logic [31:0]        r_result;

   logic               w_cdb_hit;
   logic [ENTRIES-1:0] w_ready;
   logic               w_any_free;
   idx_t               w_free_idx;
   logic               w_any_ready;
   idx_t               w_sel_idx;
   logic               w_alloc_we;
   logic               w_grant_free;
   logic [TAG_W-1:0]   w_ins_q1;
   logic [TAG_W-1:0]   w_ins_q2;
   logic [31:0]        w_ins_v1;
   logic [31:0]        w_ins_v2;

   assign w_cdb_hit    = cdb_valid && (cdb_tag != '0);
   assign w_alloc_we   = alloc_valid && w_any_free && !flush;
   assign w_grant_free = (r_state == S_BCAST) && out_grant && !flush;

   always_comb begin
      w_any_free = 1'b0;
      w_free_idx = '0;
      for (int i = ENTRIES - 1; i >= 0; i--) begin
         w_ready[i] = r_busy[i] && (r_q1[i] == '0) && (r_q2[i] == '0);
         if (!r_busy[i]) begin
            w_any_free = 1'b1;
            w_free_idx = idx_t'(i);
         end
      end
   end

   // Lowest ready slot at or above rr_ptr wins; otherwise wrap to the lowest ready slot.
   always_comb begin
      w_any_ready = |w_ready;
      w_sel_idx   = '0;
      for (int i = ENTRIES - 1; i >= 0; i--) begin
         if (w_ready[i]) w_sel_idx = idx_t'(i);
      end
      for (int i = ENTRIES - 1; i >= 0; i--) begin
         if (w_ready[i] && (idx_t'(i) >= r_rr_ptr)) w_sel_idx = idx_t'(i);
      end
   end

   always_comb begin
      w_ins_q1 = alloc_q1;
      w_ins_v1 = alloc_v1;
      w_ins_q2 = alloc_q2;
      w_ins_v2 = alloc_v2;
      if (w_cdb_hit && (alloc_q1 == cdb_tag)) begin
         w_ins_q1 = '0;
         w_ins_v1 = cdb_value;
      end
      if (w_cdb_hit && (alloc_q2 == cdb_tag)) begin
         w_ins_q2 = '0;
         w_ins_v2 = cdb_value;
      end
   end

   assign alloc_ready = w_any_free;
   assign alloc_tag   = w_any_free ? (TAG_W'(TAG_BASE) + TAG_W'(w_free_idx)) : '0;
   assign alu_valid   = (r_state == S_ISSUE) && !flush;
   assign alu_a       = (r_state == S_ISSUE) ? r_v1[r_idx] : '0;
   assign alu_b       = (r_state == S_ISSUE) ? r_v2[r_idx] : '0;
   assign out_valid   = (r_state == S_BCAST) && !flush;
   assign out_tag     = (r_state == S_BCAST) ? (TAG_W'(TAG_BASE) + TAG_W'(r_idx)) : '0;
   assign out_value   = (r_state == S_BCAST) ? r_result : '0;

   always_ff @(posedge clk or posedge RST) begin
      if (RST) begin
         r_busy <= '0;
         for (int i = 0; i < ENTRIES; i++) begin
            r_q1[i] <= '0;
            r_q2[i] <= '0;
            r_v1[i] <= '0;
            r_v2[i] <= '0;
         end
      end else if (flush) begin
         r_busy <= '0;
      end else begin
         for (int i = 0; i < ENTRIES; i++) begin
            if (w_cdb_hit && r_busy[i] && (r_q1[i] == cdb_tag)) begin
               r_q1[i] <= '0;
               r_v1[i] <= cdb_value;
            end
            if (w_cdb_hit && r_busy[i] && (r_q2[i] == cdb_tag)) begin
               r_q2[i] <= '0;
               r_v2[i] <= cdb_value;
            end
         end
         // The allocated slot is free and the granted slot is busy, so these never collide.
         if (w_alloc_we) begin
            r_busy[w_free_idx] <= 1'b1;
            r_q1[w_free_idx]   <= w_ins_q1;
            r_q2[w_free_idx]   <= w_ins_q2;
            r_v1[w_free_idx]   <= w_ins_v1;
            r_v2[w_free_idx]   <= w_ins_v2;
         end
         if (w_grant_free) r_busy[r_idx] <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge RST) begin
      if (RST) begin
         r_state  <= S_IDLE;
         r_idx    <= '0;
         r_rr_ptr <= '0;
         r_result <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (!flush && w_any_ready) begin
                  r_idx   <= w_sel_idx;
                  r_state <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (flush) begin
                  r_state <= S_IDLE;
               end else begin
                  r_state  <= S_WAIT;
                  r_rr_ptr <= (r_idx == idx_t'(ENTRIES - 1)) ? '0 : (r_idx + idx_t'(1));
               end
            end
            S_WAIT: begin
               if (flush) begin
                  r_state <= alu_done ? S_IDLE : S_DRAIN;
               end else if (alu_done) begin
                  r_result <= alu_result;
                  r_state  <= S_BCAST;
               end
            end
            S_BCAST: begin
               if (flush || out_grant) r_state <= S_IDLE;
            end
            S_DRAIN: begin
               if (alu_done) r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_rs_issue_scheduler.sv
// Bench for rs_issue_scheduler: slot-table/op-timeline model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_rs_issue_scheduler;
   localparam int N = 4;

   logic        clk = 1'b0;
   logic        RST;
   logic        flush;
   logic        alloc_valid;
   logic        alloc_ready;
   logic [7:0]  alloc_q1, alloc_q2;
   logic [31:0] alloc_v1, alloc_v2;
   logic [7:0]  alloc_tag;
   logic        cdb_valid;
   logic [7:0]  cdb_tag;
   logic [31:0] cdb_value;
   logic        alu_valid;
   logic [31:0] alu_a, alu_b;
   logic        alu_done;
   logic [31:0] alu_result;
   logic        out_valid;
   logic [7:0]  out_tag;
   logic [31:0] out_value;
   logic        out_grant;

   rs_issue_scheduler #(.ENTRIES(N), .TAG_W(8), .TAG_BASE(1)) dut (
      .clk(clk), .RST(RST), .flush(flush),
      .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
      .alloc_q1(alloc_q1), .alloc_q2(alloc_q2), .alloc_v1(alloc_v1), .alloc_v2(alloc_v2),
      .alloc_tag(alloc_tag),
      .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
      .alu_valid(alu_valid), .alu_a(alu_a), .alu_b(alu_b),
      .alu_done(alu_done), .alu_result(alu_result),
      .out_valid(out_valid), .out_tag(out_tag), .out_value(out_value),
      .out_grant(out_grant)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Model: slot table plus a description of the single op in flight.
   bit          mb [N];
   logic [7:0]  mq1 [N];
   logic [7:0]  mq2 [N];
   logic [31:0] mv1 [N];
   logic [31:0] mv2 [N];
   int          m_rr = 0;
   int          m_slot = -1;
   bit          m_issue = 0, m_wait = 0, m_res = 0, m_drain = 0;
   logic [31:0] m_result = 0;
   logic [31:0] issue_log [$];

   function automatic int lowest_free();
      for (int i = 0; i < N; i++) if (!mb[i]) return i;
      return -1;
   endfunction

   function automatic int rr_pick();
      for (int k = 0; k < N; k++) begin
         int j;
         j = (m_rr + k) % N;
         if (mb[j] && mq1[j] == 8'd0 && mq2[j] == 8'd0) return j;
      end
      return -1;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         mb[i] = 0; mq1[i] = 0; mq2[i] = 0; mv1[i] = 0; mv2[i] = 0;
      end
      m_rr = 0; m_slot = -1; m_issue = 0; m_wait = 0; m_res = 0; m_drain = 0; m_result = 0;
   endtask

   initial begin
      int lf, pick, s;
      bit hit;
      forever begin
         @(negedge clk);
         if (RST) begin
            model_reset();
            chk("rst alloc_ready", 32'(alloc_ready), 1);
            chk("rst alloc_tag", 32'(alloc_tag), 1);
            chk("rst alu_valid", 32'(alu_valid), 0);
            chk("rst alu_a", alu_a, 0);
            chk("rst alu_b", alu_b, 0);
            chk("rst out_valid", 32'(out_valid), 0);
            chk("rst out_tag", 32'(out_tag), 0);
            chk("rst out_value", out_value, 0);
         end else begin
            lf   = lowest_free();
            pick = rr_pick();
            s    = m_slot;
            chk("alloc_ready", 32'(alloc_ready), 32'(lf >= 0));
            chk("alloc_tag", 32'(alloc_tag), (lf >= 0) ? lf + 1 : 0);
            chk("alu_valid", 32'(alu_valid), 32'(m_issue && !flush));
            if (m_issue && !flush) begin
               chk("alu_a", alu_a, mv1[s]);
               chk("alu_b", alu_b, mv2[s]);
               issue_log.push_back(alu_a);
            end
            chk("out_valid", 32'(out_valid), 32'(m_res && !flush));
            if (m_res) begin
               chk("out_tag", 32'(out_tag), s + 1);
               chk("out_value", out_value, m_result);
            end
            if (m_issue) begin
               m_issue = 0;
               if (flush) m_slot = -1;
               else begin
                  m_wait = 1;
                  m_rr = (s + 1) % N;
               end
            end else if (m_wait) begin
               if (flush) begin
                  m_wait = 0; m_slot = -1; m_drain = !alu_done;
               end else if (alu_done) begin
                  m_wait = 0; m_res = 1; m_result = alu_result;
               end
            end else if (m_res) begin
               if (flush) begin
                  m_res = 0; m_slot = -1;
               end else if (out_grant) begin
                  m_res = 0; m_slot = -1; mb[s] = 0;
               end
            end else if (m_drain) begin
               if (alu_done) m_drain = 0;
            end else if (!flush && pick >= 0) begin
               m_slot = pick; m_issue = 1;
            end
            if (flush) begin
               for (int i = 0; i < N; i++) mb[i] = 0;
            end else begin
               hit = cdb_valid && cdb_tag != 8'd0;
               for (int i = 0; i < N; i++) begin
                  if (hit && mb[i] && mq1[i] == cdb_tag) begin mq1[i] = 0; mv1[i] = cdb_value; end
                  if (hit && mb[i] && mq2[i] == cdb_tag) begin mq2[i] = 0; mv2[i] = cdb_value; end
               end
               if (alloc_valid && lf >= 0) begin
                  mb[lf] = 1;
                  if (hit && alloc_q1 == cdb_tag) begin mq1[lf] = 0; mv1[lf] = cdb_value; end
                  else begin mq1[lf] = alloc_q1; mv1[lf] = alloc_v1; end
                  if (hit && alloc_q2 == cdb_tag) begin mq2[lf] = 0; mv2[lf] = cdb_value; end
                  else begin mq2[lf] = alloc_q2; mv2[lf] = alloc_v2; end
               end
            end
         end
      end
   end

   // ALU stand-in: answers a request alu_lat cycles later with a+b when alu_auto is set.
   bit          alu_auto = 1;
   int          alu_lat = 1;
   int          alu_cnt = 0;
   logic [31:0] alu_pend = 0;

   task automatic tick();
      @(negedge clk);
      if (alu_auto && alu_valid) begin
         alu_cnt  = alu_lat;
         alu_pend = alu_a + alu_b;
      end
      @(posedge clk);
      #1;
      if (alu_auto) begin
         alu_done = 1'b0;
         if (alu_cnt > 0) begin
            alu_cnt--;
            if (alu_cnt == 0) begin
               alu_done   = 1'b1;
               alu_result = alu_pend;
            end
         end
      end
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic alloc(input logic [7:0] q1, input logic [31:0] v1,
                        input logic [7:0] q2, input logic [31:0] v2);
      alloc_valid = 1'b1;
      alloc_q1 = q1; alloc_v1 = v1; alloc_q2 = q2; alloc_v2 = v2;
      tick();
      alloc_valid = 1'b0;
   endtask

   task automatic wait_out(input string name);
      int k;
      k = 0;
      #1;
      while (!out_valid && k < 30) begin
         tick(); #1; k++;
      end
      chk(name, 32'(out_valid), 1);
   endtask

   task automatic wait_alu(input string name);
      int k;
      k = 0;
      #1;
      while (!alu_valid && k < 30) begin
         tick(); #1; k++;
      end
      chk(name, 32'(alu_valid), 1);
   endtask

   logic [31:0] exp_log [5] = '{32'd10, 32'd20, 32'd30, 32'd40, 32'd50};

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   initial begin
      RST = 1'b1; flush = 1'b0; alloc_valid = 1'b0;
      alloc_q1 = 0; alloc_q2 = 0; alloc_v1 = 0; alloc_v2 = 0;
      cdb_valid = 1'b0; cdb_tag = 0; cdb_value = 0;
      alu_done = 1'b0; alu_result = 0; out_grant = 1'b0;
      run(2);
      #1;
      chk("reset alloc_tag", 32'(alloc_tag), 1);
      chk("reset out_value", out_value, 0);
      RST = 1'b0;

      // Minimum-latency path: alloc in cycle 0.
      out_grant = 1'b1;
      alloc(8'd0, 32'd5, 8'd0, 32'd7);
      #1; chk("t1 c1 alu_valid", 32'(alu_valid), 0);
      chk("t1 c1 alloc_tag", 32'(alloc_tag), 2);
      tick(); #1;
      chk("t1 c2 alu_valid", 32'(alu_valid), 1);
      chk("t1 c2 alu_a", alu_a, 5);
      chk("t1 c2 alu_b", alu_b, 7);
      tick(); #1;
      chk("t1 c3 out_valid", 32'(out_valid), 0);
      tick(); #1;
      chk("t1 c4 out_valid", 32'(out_valid), 1);
      chk("t1 c4 out_tag", 32'(out_tag), 1);
      chk("t1 c4 out_value", out_value, 12);
      tick(); #1;
      chk("t1 c5 alloc_tag", 32'(alloc_tag), 1);

      // CDB wake-up, then allocation bypass.
      alloc(8'd3, 32'd0, 8'd0, 32'd4);
      for (int i = 0; i < 3; i++) begin
         #1; chk("t2 no early issue", 32'(alu_valid), 0);
         tick();
      end
      cdb_valid = 1'b1; cdb_tag = 8'd3; cdb_value = 32'd10;
      tick();
      cdb_valid = 1'b0;
      #1; chk("t2 select cycle", 32'(alu_valid), 0);
      tick(); #1;
      chk("t2 wake alu_valid", 32'(alu_valid), 1);
      chk("t2 wake alu_a", alu_a, 10);
      chk("t2 wake alu_b", alu_b, 4);
      run(6);
      cdb_valid = 1'b1; cdb_tag = 8'd3; cdb_value = 32'd20;
      alloc(8'd3, 32'd0, 8'd0, 32'd6);
      cdb_valid = 1'b0;
      tick(); #1;
      chk("t2 bypass alu_valid", 32'(alu_valid), 1);
      chk("t2 bypass alu_a", alu_a, 20);
      chk("t2 bypass alu_b", alu_b, 6);
      run(6);

      // Fill the table, then round-robin order after a slot is reused.
      issue_log.delete();
      alloc(8'd0, 32'd10, 8'd0, 32'd1);
      alloc(8'd0, 32'd20, 8'd0, 32'd1);
      alloc(8'd0, 32'd30, 8'd0, 32'd1);
      alloc(8'd0, 32'd40, 8'd0, 32'd1);
      #1;
      chk("t3 full alloc_ready", 32'(alloc_ready), 0);
      chk("t3 full alloc_tag", 32'(alloc_tag), 0);
      chk("t3 full grant out_valid", 32'(out_valid), 1);
      tick(); #1;
      chk("t3 freed alloc_tag", 32'(alloc_tag), 1);
      alloc(8'd0, 32'd50, 8'd0, 32'd1);
      run(30);
      chk("t3 issue count", issue_log.size(), 5);
      if (issue_log.size() == 5) begin
         for (int i = 0; i < 5; i++) chk("t3 issue order", issue_log[i], exp_log[i]);
      end

      // Grant withheld for six cycles in BCAST.
      out_grant = 1'b0;
      alloc(8'd0, 32'd3, 8'd0, 32'd4);
      wait_out("t4 reach bcast");
      chk("t4 out_tag", 32'(out_tag), 1);
      chk("t4 out_value", out_value, 7);
      alloc(8'd0, 32'd8, 8'd0, 32'd9);
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("t4 hold out_valid", 32'(out_valid), 1);
         chk("t4 hold out_tag", 32'(out_tag), 1);
         chk("t4 hold out_value", out_value, 7);
         chk("t4 hold alu_valid", 32'(alu_valid), 0);
         chk("t4 hold alloc_tag", 32'(alloc_tag), 3);
         tick();
      end
      out_grant = 1'b1;
      #1; chk("t4 grant out_valid", 32'(out_valid), 1);
      tick(); #1;
      chk("t4 after grant out_valid", 32'(out_valid), 0);
      chk("t4 after grant alloc_tag", 32'(alloc_tag), 1);
      run(10);

      // Flush while waiting on the ALU; result arrives later and is dropped.
      alu_auto = 0;
      alloc(8'd77, 32'd0, 8'd0, 32'd0);
      alloc(8'd0, 32'd11, 8'd0, 32'd22);
      wait_alu("t5 reach issue");
      tick();
      flush = 1'b1;
      #1; chk("t5 flush out_valid", 32'(out_valid), 0);
      tick();
      flush = 1'b0;
      #1;
      chk("t5 cleared alloc_ready", 32'(alloc_ready), 1);
      chk("t5 cleared alloc_tag", 32'(alloc_tag), 1);
      alloc(8'd0, 32'd100, 8'd0, 32'd5);
      #1; chk("t5 drain no issue", 32'(alu_valid), 0);
      tick();
      alu_done = 1'b1; alu_result = 32'd999;
      #1; chk("t5 drain done no issue", 32'(alu_valid), 0);
      tick();
      alu_done = 1'b0;
      #1;
      chk("t5 dropped out_valid", 32'(out_valid), 0);
      chk("t5 idle select", 32'(alu_valid), 0);
      alu_auto = 1;
      tick(); #1;
      chk("t5 post-drain alu_valid", 32'(alu_valid), 1);
      chk("t5 post-drain alu_a", alu_a, 100);
      run(8);

      // Flush in the ISSUE cycle.
      alloc(8'd0, 32'd1, 8'd0, 32'd2);
      tick();
      flush = 1'b1;
      #1; chk("t5 issue flush alu_valid", 32'(alu_valid), 0);
      tick();
      flush = 1'b0;
      #1; chk("t5 issue flush alloc_tag", 32'(alloc_tag), 1);
      run(4);

      // Reset during BCAST; stray alu_done afterwards.
      out_grant = 1'b0;
      alloc(8'd0, 32'd6, 8'd0, 32'd6);
      wait_out("t6 reach bcast");
      RST = 1'b1;
      #1;
      chk("t6 rst out_valid", 32'(out_valid), 0);
      chk("t6 rst out_tag", 32'(out_tag), 0);
      chk("t6 rst out_value", out_value, 0);
      chk("t6 rst alloc_tag", 32'(alloc_tag), 1);
      tick();
      alu_auto = 0;
      RST = 1'b0;
      tick();
      alu_done = 1'b1; alu_result = 32'd55; out_grant = 1'b1;
      tick();
      alu_done = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("t6 stray alu_valid", 32'(alu_valid), 0);
         chk("t6 stray out_valid", 32'(out_valid), 0);
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
